pingpong_lutram: RTL

//   Double-buffered (ping-pong) distributed-RAM store for NPU operand vectors, e.g. one 28x28 image
//   (784 bytes). A streaming writer fills one bank while the compute array reads the other bank

---
 rtl/pingpong_lutram.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pingpong_lutram.sv
// ---------------------------------------------------------------------------
// pingpong_lutram
//   Double-buffered distributed-RAM operand store. A streaming writer fills
//   one bank with DEPTH words at auto-incremented addresses. Meanwhile the
//   compute array reads the other bank through NUM_RD asynchronous lanes.
//   The banks swap roles on a full/done handshake, so loading the next frame
//   overlaps compute on the current one.
//
// Parameters
//   BIT_DEPTH   data word width
//   DEPTH       words per bank
//   ADDR_WIDTH  address width, 2**ADDR_WIDTH >= DEPTH
//   NUM_RD      number of parallel read lanes
//
// Ports
//   clk, rst     clock (posedge) and asynchronous active-high reset
//   wr_valid     writer presents wr_data
//   wr_data      write word, stored at the internal write pointer
//   wr_ready     current write bank is not full
//   fill_count   words written so far into the current write bank
//   wr_bank      index of the bank being filled
//   rd_valid     read bank holds a complete frame
//   rd_bank      index of the bank being read
//   rd_addr      packed lane addresses, lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data      packed lane data, lane i at [i*BIT_DEPTH +: BIT_DEPTH]
//   rd_done      one-cycle pulse, reader releases the current read bank
//   err_rd_done  sticky, rd_done arrived while no frame was readable
// ---------------------------------------------------------------------------
module pingpong_lutram #(
    parameter int BIT_DEPTH  = 8,
    parameter int DEPTH      = 784,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_RD     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    input  logic [BIT_DEPTH-1:0]         wr_data,
    output logic                         wr_ready,
    output logic [ADDR_WIDTH:0]          fill_count,
    output logic                         wr_bank,
    output logic                         rd_valid,
    output logic                         rd_bank,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*BIT_DEPTH-1:0]  rd_data,
    input  logic                         rd_done,
    output logic                         err_rd_done
);

    // Memory index width: just enough bits to address DEPTH words.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);

    logic [BIT_DEPTH-1:0]  mem [2][DEPTH];
    logic [1:0]            bank_full;
    logic [1:0]            bank_full_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr;

    logic wr_fire;
    logic wr_last;
    logic rd_release;

    assign wr_ready   = ~bank_full[wr_bank];
    assign rd_valid   = bank_full[rd_bank];
    assign fill_count = {1'b0, wr_ptr};

    assign wr_fire    = wr_valid & wr_ready;
    assign wr_last    = wr_fire & (wr_ptr == LAST_PTR);
    assign rd_release = rd_done & rd_valid;

    // A final write and a release can land on the same edge; they always hit
    // different banks (write bank is never full, read bank always is), so
    // both bit updates are applied independently.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign a default
        // first so every path drives the output and no latch is inferred.
        bank_full_nxt = bank_full;
        if (wr_last)    bank_full_nxt[wr_bank] = 1'b1;
        if (rd_release) bank_full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking '<=' so every register
            // samples the pre-edge values regardless of statement order.
            wr_ptr      <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            bank_full   <= 2'b00;
            err_rd_done <= 1'b0;
        end else begin
            bank_full <= bank_full_nxt;
            if (wr_fire) begin
                if (wr_last) begin
                    wr_ptr  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_ptr  <= wr_ptr + ADDR_WIDTH'(1);
                end
            end
            if (rd_release) begin
                rd_bank <= ~rd_bank;
            end else if (rd_done) begin
                err_rd_done <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; clearing it would forbid mapping
    // onto distributed RAM, and the full/valid flags already mask stale data.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][wr_ptr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Asynchronous read lanes; out-of-range addresses read as zero.
    for (genvar g = 0; g < NUM_RD; g++) begin : g_lane
        logic [ADDR_WIDTH-1:0] lane_addr;
        logic                  lane_in_range;

        assign lane_addr     = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign lane_in_range = ({1'b0, lane_addr} < DEPTH_W);
        assign rd_data[g*BIT_DEPTH +: BIT_DEPTH] =
            lane_in_range ? mem[rd_bank][lane_addr[IDX_W-1:0]] : '0;
    end

endmodule
